vend_txn_controller: RTL and testbench
======================================

Name: vend_txn_controller

Overview:
Transaction sequencer for a multi-product coin vending unit.
- Accumulates credit from 1/2/5-rupee coin pulses.
- Accepts a product selection, checks it against configured prices, and drives a product dispenser through a request/ack handshake.
- Returns change coin-by-coin to a coin-hopper through a valid/ready handshake.
- Sits between the coin acceptor/keypad front end and the dispenser/hopper mechanics.

Parameters:
CREDIT_W, 5, width of the credit register.
MAX_CREDIT, 15, maximum credit held; coins that would exceed it are rejected.
PRICE0, 10, price of product 0 in rupees.
PRICE1, 7, price of product 1.
PRICE2, 4, price of product 2.
TIMEOUT_CYC, 16, idle cycles before auto-refund; used only with VEND_AUTO_REFUND_EN.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
rupee1  input  1  one-cycle pulse, 1-rupee coin inserted
rupee2  input  1  one-cycle pulse, 2-rupee coin inserted
rupee5  input  1  one-cycle pulse, 5-rupee coin inserted
sel_valid  input  1  selection strobe
sel  input  2  product index 0..2; 3 is invalid
cancel  input  1  refund request
disp_ready  input  1  dispenser ack, completes a vend
chg_ready  input  1  hopper accepts the current change coin
dispense  output  1  vend request, held until disp_ready
dispense_item  output  2  product being vended, stable while dispense=1
chg_valid  output  1  change coin offered
chg_coin  output  2  01=1 rupee, 10=2 rupees, 11=5 rupees; 00 when chg_valid=0
coin_reject  output  1  one-cycle pulse, inserted coin(s) returned unaccepted
err_sel  output  1  one-cycle pulse, invalid index or insufficient credit
credit  output  CREDIT_W  current credit
busy  output  1  high in VEND or CHANGE

Behaviour:
- All outputs are registered.
- Reset, synchronous, takes priority over everything:
  - State goes to IDLE and credit to 0.
  - All outputs go to 0.
  - An in-flight vend or change is abandoned without refund.
- States: IDLE, VEND, CHANGE. Encoding is free.
- IDLE, coins:
  - Sum = 1*rupee1 + 2*rupee2 + 5*rupee5; simultaneous pulses are summed.
  - If post-selection credit + sum <= MAX_CREDIT, the sum is added.
  - Otherwise the whole group is rejected: credit unchanged, coin_reject=1 next cycle.
- IDLE, selection with sel_valid=1:
  - Checked against registered credit, i.e. before same-cycle coins are added.
  - sel=3, or credit < PRICE[sel]: err_sel pulse, stay in IDLE.
  - Otherwise: credit <= credit - PRICE + accepted coins, dispense_item <= sel, dispense <= 1, go to VEND.
  - dispense rises the cycle after the sel_valid edge (latency 1).
- IDLE, cancel with credit > 0: go to CHANGE. Cancel with credit = 0 is ignored.
- IDLE, sel_valid and cancel in the same cycle: a valid selection wins; an invalid selection gives err_sel and the cancel is then honoured.
- VEND:
  - dispense held at 1 until a cycle with disp_ready=1.
  - In that cycle dispense <= 0, then go to CHANGE if credit > 0, else IDLE.
  - sel_valid and cancel are ignored.
- CHANGE:
  - Greedy coin choice from the current credit: 5 if credit >= 5, else 2 if >= 2, else 1.
  - chg_valid=1 with chg_coin stable until a cycle with chg_ready=1.
  - On that handshake credit is reduced by the coin value.
  - If the new credit is 0: chg_valid <= 0 and go to IDLE. Otherwise the next coin is offered the following cycle (back-to-back allowed).
  - chg_ready while chg_valid=0 has no effect.
- Coins arriving in VEND or CHANGE are rejected with coin_reject, and credit is not altered by them.
- Credit never exceeds MAX_CREDIT and never underflows.
- chg_valid and dispense are never high together.
- busy = (state != IDLE).

Optional Feature:
VEND_AUTO_REFUND_EN
- Defined:
  - In IDLE with credit > 0, a counter increments every cycle with no coin pulse, no sel_valid and no cancel.
  - Any such event clears the counter.
  - When the counter reaches TIMEOUT_CYC, go to CHANGE and refund all credit, exactly as for cancel.
  - The counter clears on leaving IDLE and on reset.
- Not defined: no counter exists and credit is held indefinitely.

Test Plan:
1. Exact price: rupee5, rupee5, then sel=0 -> credit 10, then dispense=1 with item 0 one cycle later; disp_ready -> IDLE, credit 0, no chg_valid.
2. Vend with change: rupee5, rupee5, sel=1 (price 7), disp_ready -> CHANGE offers 2 then 1; hold chg_ready low 3 cycles on the first coin and confirm it stays stable -> credit 0, IDLE.
3. Insufficient credit and overflow: credit 4, sel=0 -> err_sel pulse, credit stays 4. Then coins to reach 14 and insert rupee2 -> coin_reject, credit stays 14.
4. Simultaneous events: credit 7, same cycle sel=1 + rupee2 + cancel -> vend product 1, credit 2, cancel ignored, then change coin 2. Also rupee1 during VEND -> coin_reject.
5. Reset mid-change: credit 9, cancel, reset asserted after the first 5-coin handshake -> next cycle credit 0, all outputs 0, IDLE.
6. With VEND_AUTO_REFUND_EN and TIMEOUT_CYC=16: insert rupee2, wait idle -> CHANGE entered 16 cycles later, coin 2 refunded. A coin at cycle 10 restarts the count.

Source files
------------

// File: rtl/vend_txn_controller.sv
// vend_txn_controller
//   Transaction sequencer for a multi-product coin vending unit. It adds up credit from
//   1/2/5-rupee coin pulses and checks a product selection against its price. It then
//   runs the dispenser request/ack handshake and pays change one coin at a time to the
//   hopper over a valid/ready handshake.
//
//   Optional feature: define VEND_AUTO_REFUND_EN to refund all credit automatically
//   after TIMEOUT_CYC idle cycles in IDLE with non-zero credit.
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          synchronous active-high reset
//   i_rupee1/2/5     one-cycle coin pulses (simultaneous pulses are summed)
//   i_sel_valid      selection strobe, i_sel = product index 0..2 (3 invalid)
//   i_cancel         refund request
//   i_disp_ready     dispenser ack, completes a vend
//   i_chg_ready      hopper accepts the offered change coin
//   o_dispense       vend request, held until i_disp_ready
//   o_dispense_item  product being vended
//   o_chg_valid      change coin offered
//   o_chg_coin       01=1, 10=2, 11=5 rupees; 00 when o_chg_valid=0
//   o_coin_reject    one-cycle pulse, inserted coin(s) returned
//   o_err_sel        one-cycle pulse, invalid index or insufficient credit
//   o_credit         current credit
//   o_busy           high in VEND or CHANGE
module vend_txn_controller #(
    parameter int unsigned CREDIT_W    = 5,
    parameter int unsigned MAX_CREDIT  = 15,
    parameter int unsigned PRICE0      = 10,
    parameter int unsigned PRICE1      = 7,
    parameter int unsigned PRICE2      = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_rupee1,
    input  logic                i_rupee2,
    input  logic                i_rupee5,
    input  logic                i_sel_valid,
    input  logic [1:0]          i_sel,
    input  logic                i_cancel,
    input  logic                i_disp_ready,
    input  logic                i_chg_ready,
    output logic                o_dispense,
    output logic [1:0]          o_dispense_item,
    output logic                o_chg_valid,
    output logic [1:0]          o_chg_coin,
    output logic                o_coin_reject,
    output logic                o_err_sel,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_busy
);

    typedef enum logic [1:0] {StIdle, StVend, StChange} state_e;

    state_e              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_dispense;
    logic [1:0]          r_dispense_item;
    logic                r_chg_valid;
    logic [1:0]          r_chg_coin;
    logic                r_coin_reject;
    logic                r_err_sel;
    logic                r_busy;

    // Largest coin that does not exceed the remaining credit.
    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(5)) begin
            return 2'b11;
        end else if (c >= CREDIT_W'(2)) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] coin);
        case (coin)
            2'b11:   return CREDIT_W'(5);
            2'b10:   return CREDIT_W'(2);
            2'b01:   return CREDIT_W'(1);
            default: return '0;
        endcase
    endfunction

    logic [3:0]          w_sum;
    logic                w_coin_any;
    logic                w_event;
    logic [CREDIT_W-1:0] w_price;
    logic                w_sel_ok;
    logic [CREDIT_W-1:0] w_post;
    logic [CREDIT_W:0]   w_total;
    logic                w_fits;
    logic [CREDIT_W-1:0] w_idle_credit;
    logic [CREDIT_W-1:0] w_chg_credit;
    logic                w_timeout;

    assign w_sum      = {3'b000, i_rupee1} + {2'b00, i_rupee2, 1'b0} + (i_rupee5 ? 4'd5 : 4'd0);
    assign w_coin_any = i_rupee1 | i_rupee2 | i_rupee5;
    assign w_event    = w_coin_any | i_sel_valid | i_cancel;

    always_comb begin
        w_price = '0;
        case (i_sel)
            2'd0:    w_price = CREDIT_W'(PRICE0);
            2'd1:    w_price = CREDIT_W'(PRICE1);
            2'd2:    w_price = CREDIT_W'(PRICE2);
            default: w_price = '0;
        endcase
    end

    // Selection is judged on registered credit; same-cycle coins land on top of the
    // post-purchase balance.
    assign w_sel_ok      = i_sel_valid && (i_sel != 2'd3) && (r_credit >= w_price);
    assign w_post        = w_sel_ok ? (r_credit - w_price) : r_credit;
    assign w_total       = {1'b0, w_post} + (CREDIT_W + 1)'(w_sum);
    assign w_fits        = (w_total <= (CREDIT_W + 1)'(MAX_CREDIT));
    assign w_idle_credit = w_fits ? w_total[CREDIT_W-1:0] : w_post;
    assign w_chg_credit  = r_credit - coin_value(r_chg_coin);

`ifdef VEND_AUTO_REFUND_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_idle_cnt;
    logic             w_idle_tick;

    assign w_idle_tick = (r_state == StIdle) && (r_credit != '0) && !w_event;
    // Fires on the TIMEOUT_CYC-th consecutive idle cycle.
    assign w_timeout   = w_idle_tick && (r_idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idle_cnt <= '0;
        end else if (w_idle_tick && !w_timeout) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end else begin
            r_idle_cnt <= '0;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= StIdle;
            r_credit        <= '0;
            r_dispense      <= 1'b0;
            r_dispense_item <= 2'b00;
            r_chg_valid     <= 1'b0;
            r_chg_coin      <= 2'b00;
            r_coin_reject   <= 1'b0;
            r_err_sel       <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_coin_reject <= 1'b0;
            r_err_sel     <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_credit      <= w_idle_credit;
                    r_coin_reject <= w_coin_any && !w_fits;
                    if (w_sel_ok) begin
                        r_dispense      <= 1'b1;
                        r_dispense_item <= i_sel;
                        r_busy          <= 1'b1;
                        r_state         <= StVend;
                    end else begin
                        r_err_sel <= i_sel_valid;
                        // An invalid selection does not block a same-cycle cancel.
                        if ((i_cancel || w_timeout) && (w_idle_credit != '0)) begin
                            r_chg_valid <= 1'b1;
                            r_chg_coin  <= greedy_coin(w_idle_credit);
                            r_busy      <= 1'b1;
                            r_state     <= StChange;
                        end
                    end
                end
                StVend: begin
                    r_coin_reject <= w_coin_any;
                    if (i_disp_ready) begin
                        r_dispense <= 1'b0;
                        if (r_credit != '0) begin
                            r_chg_valid <= 1'b1;
                            r_chg_coin  <= greedy_coin(r_credit);
                            r_state     <= StChange;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= StIdle;
                        end
                    end
                end
                StChange: begin
                    r_coin_reject <= w_coin_any;
                    if (r_chg_valid && i_chg_ready) begin
                        r_credit <= w_chg_credit;
                        if (w_chg_credit == '0) begin
                            r_chg_valid <= 1'b0;
                            r_chg_coin  <= 2'b00;
                            r_busy      <= 1'b0;
                            r_state     <= StIdle;
                        end else begin
                            r_chg_coin <= greedy_coin(w_chg_credit);
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_dispense      = r_dispense;
    assign o_dispense_item = r_dispense_item;
    assign o_chg_valid     = r_chg_valid;
    assign o_chg_coin      = r_chg_coin;
    assign o_coin_reject   = r_coin_reject;
    assign o_err_sel       = r_err_sel;
    assign o_credit        = r_credit;
    assign o_busy          = r_busy;

endmodule

// File: tb/tb_vend_txn_controller.sv
// tb_vend_txn_controller
//   Directed, table-driven bench for vend_txn_controller with default parameters.
//   Each table record holds one cycle of inputs and the outputs expected just after
//   the following rising edge. Hand-written sequences cover reset during change and
//   idle credit retention / auto-refund.
module tb_vend_txn_controller;

    logic       i_clk;
    logic       i_reset;
    logic       i_rupee1;
    logic       i_rupee2;
    logic       i_rupee5;
    logic       i_sel_valid;
    logic [1:0] i_sel;
    logic       i_cancel;
    logic       i_disp_ready;
    logic       i_chg_ready;
    logic       o_dispense;
    logic [1:0] o_dispense_item;
    logic       o_chg_valid;
    logic [1:0] o_chg_coin;
    logic       o_coin_reject;
    logic       o_err_sel;
    logic [4:0] o_credit;
    logic       o_busy;

    vend_txn_controller dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_rupee1        (i_rupee1),
        .i_rupee2        (i_rupee2),
        .i_rupee5        (i_rupee5),
        .i_sel_valid     (i_sel_valid),
        .i_sel           (i_sel),
        .i_cancel        (i_cancel),
        .i_disp_ready    (i_disp_ready),
        .i_chg_ready     (i_chg_ready),
        .o_dispense      (o_dispense),
        .o_dispense_item (o_dispense_item),
        .o_chg_valid     (o_chg_valid),
        .o_chg_coin      (o_chg_coin),
        .o_coin_reject   (o_coin_reject),
        .o_err_sel       (o_err_sel),
        .o_credit        (o_credit),
        .o_busy          (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // {r1, r2, r5, sel_valid, sel[1:0], cancel, disp_ready, chg_ready}
    typedef logic [8:0]  vin_t;
    // {dispense, item[1:0], chg_valid, coin[1:0], reject, err_sel, credit[4:0], busy}
    typedef logic [13:0] vexp_t;

    typedef struct {
        vin_t  in;
        vexp_t exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[$];

    logic [13:0] w_act;
    assign w_act = {o_dispense, o_dispense_item, o_chg_valid, o_chg_coin, o_coin_reject,
                    o_err_sel, o_credit, o_busy};

    function automatic vin_t vi(input logic r1, input logic r2, input logic r5, input logic sv,
                                input logic [1:0] sel, input logic cn, input logic dr,
                                input logic cr);
        return {r1, r2, r5, sv, sel, cn, dr, cr};
    endfunction

    function automatic vexp_t ve(input logic disp, input logic [1:0] item, input logic cv,
                                 input logic [1:0] coin, input logic rej, input logic err,
                                 input logic [4:0] credit, input logic busy);
        return {disp, item, cv, coin, rej, err, credit, busy};
    endfunction

    task automatic add(input vin_t in, input vexp_t exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input vexp_t exp);
        n_checks++;
        if (w_act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (disp,item,cv,coin,rej,err,credit,busy)",
                     name, w_act, exp);
        end
    endtask

    // Drive inputs at the falling edge, compare just after the next rising edge.
    task automatic step(input vin_t in, input vexp_t exp, input string name);
        @(negedge i_clk);
        {i_rupee1, i_rupee2, i_rupee5, i_sel_valid, i_sel, i_cancel, i_disp_ready,
         i_chg_ready} = in;
        @(posedge i_clk);
        #1;
        check(name, exp);
    endtask

    vin_t  idle_in;
    vexp_t zero_exp;

    initial begin
        idle_in  = vi(0, 0, 0, 0, 2'd0, 0, 0, 0);
        zero_exp = ve(0, 2'd0, 0, 2'd0, 0, 0, 5'd0, 0);

        i_reset = 1'b1;
        {i_rupee1, i_rupee2, i_rupee5, i_sel_valid, i_sel, i_cancel, i_disp_ready,
         i_chg_ready} = idle_in;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        check("reset_state", zero_exp);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Exact price: 5+5, select product 0, ack.
        add(vi(0, 0, 1, 0, 2'd0, 0, 0, 0), ve(0, 2'd0, 0, 2'd0, 0, 0, 5'd5, 0));
        add(vi(0, 0, 1, 0, 2'd0, 0, 0, 0), ve(0, 2'd0, 0, 2'd0, 0, 0, 5'd10, 0));
        add(vi(0, 0, 0, 1, 2'd0, 0, 0, 0), ve(1, 2'd0, 0, 2'd0, 0, 0, 5'd0, 1));
        add(idle_in,                       ve(1, 2'd0, 0, 2'd0, 0, 0, 5'd0, 1));
        add(vi(0, 0, 0, 0, 2'd0, 0, 1, 0), ve(0, 2'd0, 0, 2'd0, 0, 0, 5'd0, 0));
        // Vend with change 3 -> coins 2 then 1, hopper stalls three cycles.
        add(vi(0, 0, 1, 0, 2'd0, 0, 0, 0), ve(0, 2'd0, 0, 2'd0, 0, 0, 5'd5, 0));
        add(vi(0, 0, 1, 0, 2'd0, 0, 0, 0), ve(0, 2'd0, 0, 2'd0, 0, 0, 5'd10, 0));
        add(vi(0, 0, 0, 1, 2'd1, 0, 0, 0), ve(1, 2'd1, 0, 2'd0, 0, 0, 5'd3, 1));
        add(vi(0, 0, 0, 0, 2'd0, 0, 1, 0), ve(0, 2'd1, 1, 2'd2, 0, 0, 5'd3, 1));
        add(idle_in,                       ve(0, 2'd1, 1, 2'd2, 0, 0, 5'd3, 1));
        add(idle_in,                       ve(0, 2'd1, 1, 2'd2, 0, 0, 5'd3, 1));
        add(idle_in,                       ve(0, 2'd1, 1, 2'd2, 0, 0, 5'd3, 1));
        add(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), ve(0, 2'd1, 1, 2'd1, 0, 0, 5'd1, 1));
        add(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), ve(0, 2'd1, 0, 2'd0, 0, 0, 5'd0, 0));
        // Insufficient credit, stray chg_ready, overflow boundary at 15.
        add(vi(0, 1, 0, 0, 2'd0, 0, 0, 0), ve(0, 2'd1, 0, 2'd0, 0, 0, 5'd2, 0));
        add(vi(0, 1, 0, 0, 2'd0, 0, 0, 0), ve(0, 2'd1, 0, 2'd0, 0, 0, 5'd4, 0));
        add(vi(0, 0, 0, 1, 2'd0, 0, 0, 0), ve(0, 2'd1, 0, 2'd0, 0, 1, 5'd4, 0));
        add(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), ve(0, 2'd1, 0, 2'd0, 0, 0, 5'd4, 0));
        add(vi(0, 0, 1, 0, 2'd0, 0, 0, 0), ve(0, 2'd1, 0, 2'd0, 0, 0, 5'd9, 0));
        add(vi(0, 0, 1, 0, 2'd0, 0, 0, 0), ve(0, 2'd1, 0, 2'd0, 0, 0, 5'd14, 0));
        add(vi(0, 1, 0, 0, 2'd0, 0, 0, 0), ve(0, 2'd1, 0, 2'd0, 1, 0, 5'd14, 0));
        add(vi(1, 0, 0, 0, 2'd0, 0, 0, 0), ve(0, 2'd1, 0, 2'd0, 0, 0, 5'd15, 0));
        add(vi(1, 0, 0, 0, 2'd0, 0, 0, 0), ve(0, 2'd1, 0, 2'd0, 1, 0, 5'd15, 0));
        // Invalid index, then invalid index + cancel: error and refund 5,5,5.
        add(vi(0, 0, 0, 1, 2'd3, 0, 0, 0), ve(0, 2'd1, 0, 2'd0, 0, 1, 5'd15, 0));
        add(vi(0, 0, 0, 1, 2'd3, 1, 0, 0), ve(0, 2'd1, 1, 2'd3, 0, 1, 5'd15, 1));
        add(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), ve(0, 2'd1, 1, 2'd3, 0, 0, 5'd10, 1));
        add(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), ve(0, 2'd1, 1, 2'd3, 0, 0, 5'd5, 1));
        add(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), ve(0, 2'd1, 0, 2'd0, 0, 0, 5'd0, 0));
        add(vi(0, 0, 0, 0, 2'd0, 1, 0, 0), ve(0, 2'd1, 0, 2'd0, 0, 0, 5'd0, 0));
        // Credit 7, sel=1 + rupee2 + cancel together; coin and selection during VEND.
        add(vi(0, 0, 1, 0, 2'd0, 0, 0, 0), ve(0, 2'd1, 0, 2'd0, 0, 0, 5'd5, 0));
        add(vi(0, 1, 0, 0, 2'd0, 0, 0, 0), ve(0, 2'd1, 0, 2'd0, 0, 0, 5'd7, 0));
        add(vi(0, 1, 0, 1, 2'd1, 1, 0, 0), ve(1, 2'd1, 0, 2'd0, 0, 0, 5'd2, 1));
        add(vi(1, 0, 0, 1, 2'd2, 0, 0, 0), ve(1, 2'd1, 0, 2'd0, 1, 0, 5'd2, 1));
        add(vi(0, 0, 0, 0, 2'd0, 0, 1, 0), ve(0, 2'd1, 1, 2'd2, 0, 0, 5'd2, 1));
        add(vi(1, 0, 0, 0, 2'd0, 0, 0, 1), ve(0, 2'd1, 0, 2'd0, 1, 0, 5'd0, 0));
        // Product 2 (price 4) from credit 5 with a simultaneous 5-coin: 5-4+5 = 6.
        add(vi(0, 0, 1, 0, 2'd0, 0, 0, 0), ve(0, 2'd1, 0, 2'd0, 0, 0, 5'd5, 0));
        add(vi(0, 0, 1, 1, 2'd2, 0, 0, 0), ve(1, 2'd2, 0, 2'd0, 0, 0, 5'd6, 1));
        add(vi(0, 0, 0, 0, 2'd0, 0, 1, 0), ve(0, 2'd2, 1, 2'd3, 0, 0, 5'd6, 1));
        add(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), ve(0, 2'd2, 1, 2'd1, 0, 0, 5'd1, 1));
        add(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), ve(0, 2'd2, 0, 2'd0, 0, 0, 5'd0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a refund: 9 -> one 5-coin handshake -> reset.
        step(vi(0, 0, 1, 0, 2'd0, 0, 0, 0), ve(0, 2'd2, 0, 2'd0, 0, 0, 5'd5, 0), "rst_c5");
        step(vi(0, 1, 0, 0, 2'd0, 0, 0, 0), ve(0, 2'd2, 0, 2'd0, 0, 0, 5'd7, 0), "rst_c7");
        step(vi(0, 1, 0, 0, 2'd0, 0, 0, 0), ve(0, 2'd2, 0, 2'd0, 0, 0, 5'd9, 0), "rst_c9");
        step(vi(0, 0, 0, 0, 2'd0, 1, 0, 0), ve(0, 2'd2, 1, 2'd3, 0, 0, 5'd9, 1), "rst_cancel");
        step(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), ve(0, 2'd2, 1, 2'd2, 0, 0, 5'd4, 1), "rst_hs5");
        @(negedge i_clk);
        i_reset = 1'b1;
        step(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), zero_exp, "rst_applied");
        @(negedge i_clk);
        i_reset = 1'b0;
        step(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), zero_exp, "rst_after");

`ifdef VEND_AUTO_REFUND_EN
        step(vi(0, 1, 0, 0, 2'd0, 0, 0, 0), ve(0, 2'd0, 0, 2'd0, 0, 0, 5'd2, 0), "ar_coin");
        for (int i = 1; i < 16; i++) begin
            step(idle_in, ve(0, 2'd0, 0, 2'd0, 0, 0, 5'd2, 0), $sformatf("ar_wait%0d", i));
        end
        step(idle_in, ve(0, 2'd0, 1, 2'd2, 0, 0, 5'd2, 1), "ar_fire");
        step(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), zero_exp, "ar_paid");
        step(vi(0, 1, 0, 0, 2'd0, 0, 0, 0), ve(0, 2'd0, 0, 2'd0, 0, 0, 5'd2, 0), "ar2_coin");
        for (int i = 1; i < 10; i++) begin
            step(idle_in, ve(0, 2'd0, 0, 2'd0, 0, 0, 5'd2, 0), $sformatf("ar2_pre%0d", i));
        end
        step(vi(1, 0, 0, 0, 2'd0, 0, 0, 0), ve(0, 2'd0, 0, 2'd0, 0, 0, 5'd3, 0), "ar2_restart");
        for (int i = 1; i < 16; i++) begin
            step(idle_in, ve(0, 2'd0, 0, 2'd0, 0, 0, 5'd3, 0), $sformatf("ar2_wait%0d", i));
        end
        step(idle_in, ve(0, 2'd0, 1, 2'd2, 0, 0, 5'd3, 1), "ar2_fire");
        step(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), ve(0, 2'd0, 1, 2'd1, 0, 0, 5'd1, 1), "ar2_hs2");
        step(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), zero_exp, "ar2_paid");
`else
        // Without auto-refund, credit is simply held while idle.
        step(vi(0, 1, 0, 0, 2'd0, 0, 0, 0), ve(0, 2'd0, 0, 2'd0, 0, 0, 5'd2, 0), "hold_coin");
        for (int i = 0; i < 24; i++) begin
            @(negedge i_clk);
            {i_rupee1, i_rupee2, i_rupee5, i_sel_valid, i_sel, i_cancel, i_disp_ready,
             i_chg_ready} = idle_in;
        end
        step(idle_in, ve(0, 2'd0, 0, 2'd0, 0, 0, 5'd2, 0), "hold_after");
        step(vi(0, 0, 0, 0, 2'd0, 1, 0, 0), ve(0, 2'd0, 1, 2'd2, 0, 0, 5'd2, 1), "hold_cancel");
        step(vi(0, 0, 0, 0, 2'd0, 0, 0, 1), zero_exp, "hold_paid");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
